// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the Yarc instruction fetch stage.
// Holds the redirect-source encoding, the fetch buffer entry layout and the target mux.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        PC_JUMP = 2'd0,
        PC_MEPC = 2'd1,
        PC_TRAP = 2'd2
    } pc_sel_t;

    typedef enum logic {
        FS_RUN       = 1'b0,
        FS_IDLE_KILL = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR             = 32'h0000_0013;
    localparam int          FETCH_MAX_OUTSTANDING = 2;

    // mtvec is direct-mode only, so its low bits are dropped together with the
    // alignment bits of every other target; misalignment is trapped later in EX.
    function automatic logic [31:0] redirect_target(
        input pc_sel_t     sel,
        input logic [31:0] branch_target,
        input logic [31:0] mepc,
        input logic [31:0] mtvec
    );
        logic [31:0] t;
        case (sel)
            PC_MEPC: t = mepc;
            PC_TRAP: t = mtvec;
            default: t = branch_target;
        endcase
        return t & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Pipelined instruction-memory bus: per-cycle request offer, in-order responses.
interface instr_fetch_if;

    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry synchronous FIFO of {pc, instr} sitting between the memory bus and IF/ID.
// Clear beats push and pop; the head is read combinationally.
module fetch_buffer
    import instr_fetch_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic [1:0]   count_o
);

    fetch_entry_t r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign w_do_pop  = pop_i && (r_count != 2'd0);
    assign w_do_push = push_i && ((r_count != 2'd2) || w_do_pop);

    always_ff @(posedge clk_i) begin
        if (w_do_push && !clear_i) begin
            r_mem[r_wr_ptr] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
        end
    end

    assign head_o  = r_mem[r_rd_ptr];
    assign count_o = r_count;

endmodule

// File: rtl/instr_fetch.sv
// Yarc IF stage: fetch PC, credit-limited imem requests, stale-response killing,
// fetch buffer and the IF/ID register.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] BOOT_PC = 32'h0000_0000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          new_pc_en_i,
    input  pc_sel_t       pc_sel_i,
    input  logic [31:0]   branch_target_i,
    input  logic [31:0]   mepc_i,
    input  logic [31:0]   mtvec_i,
    input  logic          if_stall_i,
    input  logic          if_flush_i,
    instr_fetch_if.master imem,
    output logic [31:0]   if_id_instr_o,
    output logic [31:0]   if_id_pc_o,
    output logic          if_id_instr_valid_o,
    output logic [31:0]   if_pc_o
);

    logic [31:0]  r_fetch_pc;
    logic [31:0]  r_dpc;
    logic [1:0]   r_outstanding;
    logic [1:0]   r_kill_cnt;
    fetch_state_t r_state;
    logic [31:0]  r_if_id_instr;
    logic [31:0]  r_if_id_pc;
    logic         r_if_id_valid;

    logic [31:0]  w_target;
    logic [1:0]   w_fifo_count;
    fetch_entry_t w_fifo_head;
    fetch_entry_t w_push_data;
    logic [31:0]  w_rsp_pc;
    logic         w_credit_ok;
    logic         w_grant;
    logic         w_live;
    logic         w_load;
    logic         w_pop;
    logic         w_bypass;
    logic         w_push;
    logic [1:0]   w_kill_new;
    logic [1:0]   w_outstanding_next;

    assign w_target = redirect_target(pc_sel_i, branch_target_i, mepc_i, mtvec_i);

    // Killed requests still hold a credit until their response comes back.
    assign w_credit_ok = ({1'b0, r_outstanding} + {1'b0, w_fifo_count})
                         < 3'(FETCH_MAX_OUTSTANDING);

    assign imem.req  = !rst_i && !new_pc_en_i && w_credit_ok;
    assign imem.addr = r_fetch_pc;

    assign w_grant = imem.req && imem.gnt;
    assign w_live  = imem.rvalid && !new_pc_en_i && (r_state == FS_RUN);
    assign w_load  = !new_pc_en_i && !if_stall_i && !if_flush_i;

    // Buffered entries are dpc, dpc+4, ... so a live response follows them.
    assign w_rsp_pc    = r_dpc + {28'd0, w_fifo_count, 2'b00};
    assign w_push_data = '{pc: w_rsp_pc, instr: imem.rdata};

    assign w_pop    = w_load && (w_fifo_count != 2'd0);
    assign w_bypass = w_load && (w_fifo_count == 2'd0) && w_live;
    assign w_push   = w_live && !w_bypass;

    assign w_kill_new         = r_outstanding - {1'b0, imem.rvalid};
    assign w_outstanding_next = r_outstanding + {1'b0, w_grant} - {1'b0, imem.rvalid};

    fetch_buffer u_fetch_buffer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (new_pc_en_i),
        .push_i      (w_push),
        .push_data_i (w_push_data),
        .pop_i       (w_pop),
        .head_o      (w_fifo_head),
        .count_o     (w_fifo_count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fetch_pc    <= BOOT_PC;
            r_dpc         <= BOOT_PC;
            r_outstanding <= 2'd0;
            r_kill_cnt    <= 2'd0;
            r_state       <= FS_RUN;
            r_if_id_valid <= 1'b0;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_pc    <= 32'h0000_0000;
        end else begin
            r_outstanding <= w_outstanding_next;
            if (new_pc_en_i) begin
                r_fetch_pc    <= w_target;
                r_dpc         <= w_target;
                r_kill_cnt    <= w_kill_new;
                r_state       <= (w_kill_new != 2'd0) ? FS_IDLE_KILL : FS_RUN;
                r_if_id_valid <= 1'b0;
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if ((r_state == FS_IDLE_KILL) && imem.rvalid) begin
                    r_kill_cnt <= r_kill_cnt - 2'd1;
                    if (r_kill_cnt == 2'd1) begin
                        r_state <= FS_RUN;
                    end
                end
                if (w_pop) begin
                    r_if_id_valid <= 1'b1;
                    r_if_id_pc    <= w_fifo_head.pc;
                    r_if_id_instr <= w_fifo_head.instr;
                    r_dpc         <= r_dpc + 32'd4;
                end else if (w_bypass) begin
                    r_if_id_valid <= 1'b1;
                    r_if_id_pc    <= w_rsp_pc;
                    r_if_id_instr <= imem.rdata;
                    r_dpc         <= r_dpc + 32'd4;
                end else if (w_load || if_flush_i) begin
                    r_if_id_valid <= 1'b0;
                end
            end
        end
    end

    assign if_id_instr_o       = r_if_id_instr;
    assign if_id_pc_o          = r_if_id_pc;
    assign if_id_instr_valid_o = r_if_id_valid;
    assign if_pc_o             = r_if_id_valid ? r_if_id_pc : r_dpc;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: behavioural imem with variable latency and
// grant, scoreboard of granted fetches compared against IF/ID deliveries.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam logic [31:0] BOOT = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        new_pc_en;
    pc_sel_t     pc_sel;
    logic [31:0] br_tgt;
    logic [31:0] mepc;
    logic [31:0] mtvec;
    logic        stall;
    logic        flush;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_valid;
    logic [31:0] if_pc;

    instr_fetch_if imem_bus ();

    instr_fetch #(.BOOT_PC(BOOT)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .new_pc_en_i         (new_pc_en),
        .pc_sel_i            (pc_sel),
        .branch_target_i     (br_tgt),
        .mepc_i              (mepc),
        .mtvec_i             (mtvec),
        .if_stall_i          (stall),
        .if_flush_i          (flush),
        .imem                (imem_bus),
        .if_id_instr_o       (id_instr),
        .if_id_pc_o          (id_pc),
        .if_id_instr_valid_o (id_valid),
        .if_pc_o             (if_pc)
    );

    always #5 clk = ~clk;

    mreq_t        mq[$];
    fetch_entry_t sb[$];
    int           n_total = 0;
    int           n_bad = 0;
    int           cyc = 0;
    int           lat = 1;
    int           last_due = 0;
    bit           gnt_rand = 1'b0;
    logic [31:0]  model_pc = BOOT;
    bit           prev_load = 1'b0;
    bit           prev_kill = 1'b0;
    bit           prev_stall = 1'b0;
    logic         held_valid = 1'b0;
    logic [31:0]  held_pc = '0;
    logic [31:0]  hpc;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] tgt_of(input pc_sel_t s, input logic [31:0] bt,
                                           input logic [31:0] ep, input logic [31:0] tv);
        logic [31:0] t;
        case (s)
            PC_MEPC: t = ep;
            PC_TRAP: t = {tv[31:2], 2'b00};
            default: t = bt;
        endcase
        return {t[31:2], 2'b00};
    endfunction

    task automatic monitor();
        fetch_entry_t e;
        mreq_t        m;
        if (rst) begin
            mq.delete();
            sb.delete();
            model_pc   = BOOT;
            last_due   = 0;
            prev_load  = 1'b0;
            prev_kill  = 1'b0;
            prev_stall = 1'b0;
            return;
        end
        if (prev_load && id_valid) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("dlv_pc", id_pc, e.pc);
                chk("dlv_instr", id_instr, e.instr);
            end
        end
        if (prev_kill) chk("killed_valid", 32'(id_valid), 32'd0);
        if (prev_stall) begin
            chk("stall_hold_valid", 32'(id_valid), 32'(held_valid));
            if (held_valid) chk("stall_hold_pc", id_pc, held_pc);
        end
        if (imem_bus.req && imem_bus.gnt) begin
            chk("req_addr", imem_bus.addr, model_pc);
            sb.push_back('{pc: model_pc, instr: mem_word(model_pc)});
            m.addr   = model_pc;
            m.due    = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            last_due = m.due;
            mq.push_back(m);
            model_pc = model_pc + 32'd4;
        end
        if (imem_bus.rvalid && mq.size() != 0) void'(mq.pop_front());
        if (new_pc_en) begin
            chk("redir_req", 32'(imem_bus.req), 32'd0);
            sb.delete();
            model_pc = tgt_of(pc_sel, br_tgt, mepc, mtvec);
        end
        prev_load  = !new_pc_en && !stall && !flush;
        prev_kill  = new_pc_en || flush;
        prev_stall = !new_pc_en && !flush && stall;
        held_valid = id_valid;
        held_pc    = id_pc;
    endtask

    task automatic drive_mem();
        imem_bus.gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            imem_bus.rvalid = 1'b1;
            imem_bus.rdata  = mem_word(mq[0].addr);
        end else begin
            imem_bus.rvalid = 1'b0;
            imem_bus.rdata  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        drive_mem();
        #1;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!id_valid && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, 32'(id_valid), 32'd1);
    endtask

    task automatic wait_outstanding(input string tag, input int budget);
        int n = 0;
        while (mq.size() < 2 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_outstanding"}, 32'(mq.size()), 32'd2);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req"}, 32'(imem_bus.req), 32'd0);
        chk({tag, "_addr"}, imem_bus.addr, BOOT);
        chk({tag, "_valid"}, 32'(id_valid), 32'd0);
        chk({tag, "_instr"}, id_instr, NOP_INSTR);
        chk({tag, "_pc"}, id_pc, 32'd0);
        chk({tag, "_if_pc"}, if_pc, BOOT);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; new_pc_en = 1'b0; pc_sel = PC_JUMP; br_tgt = '0; mepc = '0; mtvec = '0;
        stall = 1'b0; flush = 1'b0;
        imem_bus.gnt = 1'b1; imem_bus.rvalid = 1'b0; imem_bus.rdata = '0;
        repeat (3) tick();
        check_reset("rst");

        // Boot streaming with gnt=1 and 1-cycle memory
        rst = 1'b0;
        #1;
        chk("boot_req0", 32'(imem_bus.req), 32'd1);
        chk("boot_addr0", imem_bus.addr, 32'h0);
        tick();
        chk("boot_addr1", imem_bus.addr, 32'h4);
        tick();
        chk("boot_addr2", imem_bus.addr, 32'h8);
        chk("boot_valid", 32'(id_valid), 32'd1);
        chk("boot_pc0", id_pc, 32'h0);
        tick();
        chk("boot_pc1", id_pc, 32'h4);
        tick();
        chk("boot_pc2", id_pc, 32'h8);
        repeat (3) tick();

        // Stall for 4 cycles while streaming
        hpc = id_pc;
        stall = 1'b1;
        repeat (4) tick();
        chk("stall_req_low", 32'(imem_bus.req), 32'd0);
        chk("stall_buffered_le2", 32'(sb.size() <= 2), 32'd1);
        chk("stall_if_pc", if_pc, hpc);
        stall = 1'b0;
        tick();
        chk("rel_pc1", id_pc, hpc + 32'd4);
        tick();
        chk("rel_pc2", id_pc, hpc + 32'd8);
        tick();
        chk("rel_pc3", id_pc, hpc + 32'd12);

        // Branch with two outstanding requests and 3-cycle memory
        lat = 3;
        wait_outstanding("br", 20);
        new_pc_en = 1'b1; pc_sel = PC_JUMP; br_tgt = 32'h0000_0102;
        #1;
        chk("br_req_low", 32'(imem_bus.req), 32'd0);
        tick();
        new_pc_en = 1'b0;
        #1;
        chk("br_addr", imem_bus.addr, 32'h100);
        chk("br_invalid", 32'(id_valid), 32'd0);
        wait_valid("br", 20);
        chk("br_first_pc", id_pc, 32'h100);
        chk("br_first_instr", id_instr, mem_word(32'h100));

        // MRET redirect with 1-cycle memory, then trap while stalled
        lat = 1;
        repeat (8) tick();
        new_pc_en = 1'b1; pc_sel = PC_MEPC; mepc = 32'h0000_0040;
        #1;
        chk("mret_req_low", 32'(imem_bus.req), 32'd0);
        tick();
        new_pc_en = 1'b0;
        #1;
        chk("mret_req_n1", 32'(imem_bus.req), 32'd1);
        chk("mret_addr_n1", imem_bus.addr, 32'h40);
        tick();
        tick();
        chk("mret_valid_n3", 32'(id_valid), 32'd1);
        chk("mret_pc_n3", id_pc, 32'h40);
        stall = 1'b1;
        #1;
        chk("irq_if_pc", if_pc, 32'h40);
        repeat (2) tick();
        chk("irq_if_pc_held", if_pc, 32'h40);
        new_pc_en = 1'b1; pc_sel = PC_TRAP; mtvec = 32'h0000_0203;
        tick();
        new_pc_en = 1'b0;
        #1;
        chk("trap_invalid", 32'(id_valid), 32'd0);
        chk("trap_addr", imem_bus.addr, 32'h200);
        chk("trap_if_pc", if_pc, 32'h200);
        stall = 1'b0;
        wait_valid("trap", 10);
        chk("trap_first_pc", id_pc, 32'h200);

        // Flush together with stall while the buffer is full
        repeat (6) tick();
        hpc = id_pc;
        stall = 1'b1;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("flush_invalid", 32'(id_valid), 32'd0);
        chk("flush_if_pc", if_pc, hpc + 32'd4);
        stall = 1'b0;
        tick();
        chk("flush_next_pc1", id_pc, hpc + 32'd4);
        tick();
        chk("flush_next_pc2", id_pc, hpc + 32'd8);

        // Reset with two requests in flight
        lat = 3;
        wait_outstanding("mrst", 20);
        rst = 1'b1;
        tick();
        check_reset("mrst");
        rst = 1'b0;
        lat = 1;
        #1;
        chk("mrst_req", 32'(imem_bus.req), 32'd1);
        chk("mrst_addr", imem_bus.addr, BOOT);
        tick();
        tick();
        chk("mrst_first_pc", id_pc, BOOT);
        chk("mrst_first_valid", 32'(id_valid), 32'd1);

        // Random grant, stalls, flushes and redirects
        gnt_rand = 1'b1;
        lat = 2;
        for (int i = 0; i < 300; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 15) == 0);
            new_pc_en = ($urandom_range(0, 31) == 0);
            pc_sel = pc_sel_t'($urandom_range(0, 2));
            br_tgt = 32'h0000_1000 + 32'($urandom_range(0, 1023));
            mepc   = 32'h0000_2000 + 32'($urandom_range(0, 1023));
            mtvec  = 32'h0000_3000 + 32'($urandom_range(0, 1023));
            tick();
        end
        stall = 1'b0; flush = 1'b0; new_pc_en = 1'b0; gnt_rand = 1'b0;
        repeat (10) tick();
        chk("final_valid", 32'(id_valid), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
